// File: rtl/m_7segdec_scan.sv
// m_7segdec_scan: reads a scanned 7-segment bus back into per-digit values.
// Optional SEG7DEC_HEX_EN additionally accepts the A..F glyphs as valid digits.
`default_nettype none
`timescale 1ns/1ps

module m_7segdec_scan #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic                w_clk,
  input  logic                w_rst,
  input  logic [6:0]          w_seg,
  input  logic [NDIG-1:0]     w_sel,
  input  logic                w_clr,
  output logic [4*NDIG-1:0]   r_val,
  output logic [NDIG-1:0]     r_vld,
  output logic                r_upd,
  output logic                r_err
);

  localparam int            CW      = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_DONE = 2'd2} state_t;

  logic [NDIG+6:0] smp_q, prv_q;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            commit_d;

  logic [NDIG-1:0] smp_sel;
  logic [6:0]      smp_seg;
  logic            onehot, same;
  logic [3:0]      dec_dig;
  logic            dec_ok, dec_blank;

  assign smp_sel = smp_q[NDIG+6:7];
  assign smp_seg = smp_q[6:0];
  assign onehot  = (smp_sel != '0) && ((smp_sel & (smp_sel - NDIG'(1))) == '0);
  assign same    = (smp_q == prv_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    if (!onehot) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_TRACK && same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end else if (state_q == S_DONE && same) begin
      state_d = S_DONE;
    end else begin
      state_d = S_TRACK;
      cnt_d   = CNT_ONE;
    end
    // Reaching the threshold commits on this same edge, including STABLE=1.
    if (onehot && state_d == S_TRACK && cnt_d == CNT_MAX) begin
      commit_d = 1'b1;
      state_d  = S_DONE;
    end
  end

  always_comb begin
    dec_dig   = 4'h0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (smp_seg)
      7'b1111110: dec_dig = 4'h0;
      7'b0110000: dec_dig = 4'h1;
      7'b1101101: dec_dig = 4'h2;
      7'b1111001: dec_dig = 4'h3;
      7'b0110011: dec_dig = 4'h4;
      7'b1011011: dec_dig = 4'h5;
      7'b1011111: dec_dig = 4'h6;
      7'b1110000: dec_dig = 4'h7;
      7'b1111111: dec_dig = 4'h8;
      7'b1111011: dec_dig = 4'h9;
`ifdef SEG7DEC_HEX_EN
      7'b1110111: dec_dig = 4'hA;
      7'b0011111: dec_dig = 4'hB;
      7'b1001110: dec_dig = 4'hC;
      7'b0111101: dec_dig = 4'hD;
      7'b1001111: dec_dig = 4'hE;
      7'b1000111: dec_dig = 4'hF;
`endif
      7'b0000000: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      smp_q   <= '0;
      prv_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_val   <= '0;
      r_vld   <= '0;
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      smp_q   <= {w_sel, w_seg};
      prv_q   <= smp_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_upd   <= commit_d && (dec_ok || dec_blank);
      // An error commit on the same edge as a clear keeps the flag set.
      if (commit_d && !dec_ok && !dec_blank)
        r_err <= 1'b1;
      else if (w_clr)
        r_err <= 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        if (commit_d && smp_sel[k]) begin
          if (dec_ok) begin
            r_val[4*k +: 4] <= dec_dig;
            r_vld[k]        <= 1'b1;
          end else if (dec_blank) begin
            r_vld[k] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_7segdec_scan.sv
// tb_m_7segdec_scan: directed and random scan traffic against a run-length reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_m_7segdec_scan;
  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic [6:0]          seg = '0;
  logic [NDIG-1:0]     sel = '0;
  logic [4*NDIG-1:0]   val;
  logic [NDIG-1:0]     vld;
  logic                upd, err;

  always #5 clk = ~clk;

  m_7segdec_scan #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .w_clk(clk), .w_rst(rst), .w_seg(seg), .w_sel(sel), .w_clr(clr),
    .r_val(val), .r_vld(vld), .r_upd(upd), .r_err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Glyph table indexed by digit value; entries 10..15 only count with the hex option.
  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`ifdef SEG7DEC_HEX_EN
  localparam int NPAT = 16;
`else
  localparam int NPAT = 10;
`endif

  // Returns digit value, 16 for blank, -1 for an undecodable pattern.
  function automatic int decode(input logic [6:0] s);
    if (s == 7'b0) return 16;
    for (int i = 0; i < NPAT; i++)
      if (glyph[i] == s) return i;
    return -1;
  endfunction

  logic [3:0]        m_val [NDIG];
  logic [NDIG-1:0]   m_vld;
  bit                m_upd, m_err;
  logic [NDIG+6:0]   last_x, pend_x;
  int                run;
  bit                pend;

  task automatic model_reset();
    for (int k = 0; k < NDIG; k++) m_val[k] = 4'h0;
    m_vld  = '0;
    m_upd  = 1'b0;
    m_err  = 1'b0;
    last_x = '0;
    pend_x = '0;
    run    = 0;
    pend   = 1'b0;
  endtask

  // Called right after an active edge: resolves the commit decided by the
  // previous sample, then tallies how long the current sample has been held.
  task automatic model_edge();
    logic [NDIG+6:0] x;
    bit ecommit;
    int d;
    ecommit = 1'b0;
    m_upd   = 1'b0;
    if (pend) begin
      d = decode(pend_x[6:0]);
      if (d < 0) begin
        ecommit = 1'b1;
        m_err   = 1'b1;
      end else begin
        m_upd = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
          if (pend_x[7+k]) begin
            if (d == 16) m_vld[k] = 1'b0;
            else begin
              m_val[k] = 4'(d);
              m_vld[k] = 1'b1;
            end
          end
        end
      end
    end
    if (!ecommit && clr) m_err = 1'b0;
    x = {sel, seg};
    if ($countones(sel) == 1) run = (x == last_x) ? run + 1 : 1;
    else                      run = 0;
    last_x = x;
    pend   = (run == STABLE);
    pend_x = x;
  endtask

  task automatic compare_all(input string tag);
    logic [4*NDIG-1:0] pv;
    for (int k = 0; k < NDIG; k++) pv[4*k +: 4] = m_val[k];
    check({tag, ".val"}, 32'(val), 32'(pv));
    check({tag, ".vld"}, 32'(vld), 32'(m_vld));
    check({tag, ".upd"}, 32'(upd), 32'(m_upd));
    check({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic cyc(input string tag, input logic [NDIG-1:0] s, input logic [6:0] g, input bit c);
    sel = s;
    seg = g;
    clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) cyc("hold3", 4'b0001, 7'b1111001, 1'b0);

    cyc("gap", 4'b0000, 7'b1111001, 1'b0);
    for (int i = 0; i < 2; i++) cyc("pre_rst", 4'b0001, 7'b1111001, 1'b0);
    async_reset("mid_rst");
    for (int i = 0; i < 6; i++) cyc("post_rst", 4'b0001, 7'b1111001, 1'b0);

    for (int i = 0; i < 2; i++) cyc("five", 4'b0100, 7'b1011011, 1'b0);
    for (int i = 0; i < 5; i++) cyc("seven", 4'b0100, 7'b1110000, 1'b0);

    for (int i = 0; i < 5; i++) cyc("hexA", 4'b0010, 7'b1110111, 1'b0);
    cyc("clr", 4'b0000, 7'b0000000, 1'b1);
    cyc("clr_after", 4'b0000, 7'b0000000, 1'b0);

    for (int i = 0; i < 5; i++) cyc("blank", 4'b0100, 7'b0000000, 1'b0);

    for (int i = 0; i < 10; i++) cyc("multi", 4'b0011, 7'b1111110, 1'b0);
    for (int i = 0; i < 10; i++) cyc("nosel", 4'b0000, 7'b1111110, 1'b0);

    // Clear coinciding with an error commit: the error must win.
    for (int i = 0; i < 2; i++) cyc("err_pre", 4'b1000, 7'b1010101, 1'b0);
    cyc("err_clr", 4'b1000, 7'b1010101, 1'b1);
    cyc("err_win", 4'b1000, 7'b1010101, 1'b1);

    for (int n = 0; n < 300; n++) begin
      logic [NDIG-1:0] rs;
      logic [6:0]      rg;
      int              r, hold;
      r = $urandom_range(0, 9);
      if (r < 7)       rs = NDIG'(1) << $urandom_range(0, NDIG - 1);
      else if (r == 7) rs = '0;
      else             rs = NDIG'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)       rg = glyph[$urandom_range(0, 15)];
      else if (r == 6) rg = 7'b0;
      else             rg = 7'($urandom);
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++)
        cyc("rand", rs, rg, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
